// File: rtl/pixel_stream_pkg.sv
// Shared definitions for the pixel stream path: host word geometry, lane math
// and the packed-word record carried between packer and serializer.
package pixel_stream_pkg;

  localparam int HOST_LOGBITS = 6;
  localparam int HOST_WIDTH   = 1 << HOST_LOGBITS;
  localparam int MIN_INLOGBITS = 3;

  function automatic int ratio(input int inlog, input int outlog);
    return 1 << (outlog - inlog);
  endfunction

  // Wide enough to hold RATIO itself, not just RATIO-1.
  function automatic int count_bits(input int inlog, input int outlog);
    return outlog - inlog + 1;
  endfunction

  // Host-width record sized for the narrowest legal element; the packer
  // declares its own instance of the same layout at its parameterised widths.
  typedef struct packed {
    logic [HOST_WIDTH-1:0]                             data;
    logic                                              last;
    logic [HOST_LOGBITS-MIN_INLOGBITS:0]               count;
  } host_word_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry register FIFO; push_ready depends only on occupancy, so upstream
// ready never has a combinational path from pop_ready.
module stream_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [DW-1:0] push_data,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [DW-1:0] pop_data
);

  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;
  logic [1:0]    occ;
  logic          push;
  logic          pop;

  assign push_ready = (occ != 2'd2);
  assign pop_valid  = (occ != 2'd0);
  assign pop_data   = slot0;
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  // slot0 is always the head; slot1 only holds data when occ == 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs narrow pixel elements into host words, lane 0 in the LSBs, with
// in_last flushing a partial word and a 2-entry buffer on the output side.
module pixel_packer
  import pixel_stream_pkg::*;
#(
  parameter int INLOGBITS  = 5,
  parameter int OUTLOGBITS = HOST_LOGBITS,
  localparam int W     = 1 << INLOGBITS,
  localparam int OW    = 1 << OUTLOGBITS,
  localparam int RATIO = ratio(INLOGBITS, OUTLOGBITS),
  localparam int CW    = count_bits(INLOGBITS, OUTLOGBITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] out_count,
  output logic [31:0]   words_out
);

  localparam int LW = CW - 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(RATIO - 1);

  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
    logic [CW-1:0] count;
  } word_t;

  logic [OW-1:0] acc;
  logic [LW-1:0] lane;
  word_t         next_word;
  word_t         head;
  logic          fifo_ready;
  logic          accept;
  logic          commit;

  // Handshake: a transfer happens on any cycle where valid && ready are both
  // high, on either side; nothing else qualifies it.
  assign in_ready = !rst && fifo_ready;
  assign accept   = in_valid && in_ready;
  assign commit   = accept && (in_last || lane == LANE_MAX);

  // Lanes above the current one are still zero because acc clears on commit.
  always_comb begin
    next_word.data = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == LW'(k)) next_word.data[k*W +: W] = in_data;
    end
    next_word.last  = in_last;
    next_word.count = CW'(lane) + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      lane      <= '0;
      words_out <= 32'd0;
    end else begin
      if (accept) begin
        if (commit) begin
          acc  <= '0;
          lane <= '0;
        end else begin
          acc  <= next_word.data;
          lane <= lane + LW'(1);
        end
      end
      if (out_valid && out_ready) words_out <= words_out + 32'd1;
    end
  end

  stream_fifo2 #(
    .DW($bits(word_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (commit),
    .push_ready (fifo_ready),
    .push_data  (next_word),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head)
  );

  assign out_data  = head.data;
  assign out_last  = head.last;
  assign out_count = head.count;

endmodule
